// File: rtl/csa_cpa_resolve_if.sv
// Handshake and data bundle for csa_cpa_resolve.
// slave: the resolver's view; master: the producer/consumer side that drives it.
interface csa_cpa_resolve_if #(
    parameter int S_WIDTH = 25,
    parameter int C_WIDTH = 26
);
    localparam int R_WIDTH = C_WIDTH + 1;

    logic               in_valid;
    logic               in_ready;
    logic [S_WIDTH:1]   s_in;
    logic [C_WIDTH:1]   c_in;
    logic               out_valid;
    logic               out_ready;
    logic [R_WIDTH:1]   sum_out;
    logic               busy;

    modport slave (
        input  in_valid, s_in, c_in, out_ready,
        output in_ready, out_valid, sum_out, busy
    );

    modport master (
        output in_valid, s_in, c_in, out_ready,
        input  in_ready, out_valid, sum_out, busy
    );
endinterface

// File: rtl/csa_cpa_resolve.sv
// csa_cpa_resolve: iterative carry-propagate adder that collapses a carry-save
// (sum, carry) pair into one binary result, CHUNK bits per cycle through a
// registered carry. Optional feature macro: CSA_CPA_LSB_CHECK_EN adds lsb_err,
// which flags a set carry-vector LSB for the result being presented.
module csa_cpa_resolve #(
    parameter int S_WIDTH = 25,
    parameter int C_WIDTH = 26,
    parameter int CHUNK   = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    csa_cpa_resolve_if.slave     bus
`ifdef CSA_CPA_LSB_CHECK_EN
    ,
    output logic                 lsb_err
`endif
);
    localparam int R_WIDTH  = C_WIDTH + 1;
    localparam int NCHK     = (C_WIDTH + CHUNK - 1) / CHUNK;
    localparam int PAD_W    = NCHK * CHUNK;
    localparam int LAST_W   = C_WIDTH - (NCHK - 1) * CHUNK;
    localparam int CNT_W    = (NCHK > 1) ? $clog2(NCHK) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NCHK - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q;
    logic [PAD_W-1:0]   a_q;
    logic [PAD_W-1:0]   b_q;
    logic [R_WIDTH-1:0] sum_q;
    logic [R_WIDTH-1:0] sum_d;
    logic               carry_q;
    logic               carry_d;
    logic [CNT_W-1:0]   chunk_q;
    logic               out_valid_q;
    logic               busy_q;
    logic [CHUNK:0]     slice;
    logic               in_ready;
    logic               accept;
    logic               last_chunk;
`ifdef CSA_CPA_LSB_CHECK_EN
    logic               lsb_q;
`endif

    // Handshake decode: a finished result can be swapped for a new operand pair in one edge
    always_comb begin
        in_ready   = (state_q == IDLE) || ((state_q == DONE) && bus.out_ready);
        accept     = bus.in_valid && in_ready;
        last_chunk = (chunk_q == LAST_CNT);
    end

    // One slice of the carry-propagate add; operands are shifted down so the slice is always the low CHUNK bits
    always_comb begin
        int unsigned        base;
        logic [R_WIDTH-1:0] mask;
        logic [R_WIDTH-1:0] ins;
        slice   = {1'b0, a_q[CHUNK-1:0]} + {1'b0, b_q[CHUNK-1:0]} + {{CHUNK{1'b0}}, carry_q};
        // the last slice can be narrower, so its carry-out sits at bit LAST_W, not CHUNK
        carry_d = last_chunk ? slice[LAST_W] : slice[CHUNK];
        base    = 32'(chunk_q) * CHUNK;
        mask    = R_WIDTH'({CHUNK{1'b1}}) << base;
        ins     = R_WIDTH'(slice[CHUNK-1:0]) << base;
        sum_d   = (sum_q & ~mask) | ins;
        if (last_chunk) begin
            sum_d[C_WIDTH] = carry_d;
        end
    end

    // Control FSM, operand/carry datapath and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            carry_q     <= 1'b0;
            chunk_q     <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
`ifdef CSA_CPA_LSB_CHECK_EN
            lsb_q       <= 1'b0;
`endif
        end else begin
            case (state_q)
                ADD: begin
                    a_q     <= a_q >> CHUNK;
                    b_q     <= b_q >> CHUNK;
                    sum_q   <= sum_d;
                    carry_q <= carry_d;
                    if (last_chunk) begin
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                        busy_q      <= 1'b0;
                    end else begin
                        chunk_q <= chunk_q + 1'b1;
                    end
                end
                DONE: begin
                    if (bus.out_ready && !accept) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
            // accept is only possible from IDLE or DONE, and overrides their default moves
            if (accept) begin
                state_q     <= ADD;
                a_q         <= PAD_W'(bus.s_in);
                b_q         <= PAD_W'(bus.c_in);
                carry_q     <= 1'b0;
                chunk_q     <= '0;
                out_valid_q <= 1'b0;
                busy_q      <= 1'b1;
`ifdef CSA_CPA_LSB_CHECK_EN
                lsb_q       <= bus.c_in[1];
`endif
            end
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.sum_out   = sum_q;
    assign bus.busy      = busy_q;
`ifdef CSA_CPA_LSB_CHECK_EN
    assign lsb_err       = out_valid_q & lsb_q;
`endif

endmodule

// File: tb/tb_csa_cpa_resolve.sv
// Scoreboard bench for csa_cpa_resolve: the driver pushes hand-computed results,
// an independent monitor pops and compares on every output handshake.
module tb_csa_cpa_resolve;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_mis = 0;

    typedef struct {
        logic [26:0] sum;
        logic        lsb;
        int          acc;
    } exp_t;
    exp_t exp_q[$];

    csa_cpa_resolve_if #(.S_WIDTH(25), .C_WIDTH(26)) bus();

`ifdef CSA_CPA_LSB_CHECK_EN
    logic lsb_err;
`endif

    csa_cpa_resolve #(.S_WIDTH(25), .C_WIDTH(26), .CHUNK(8)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus)
`ifdef CSA_CPA_LSB_CHECK_EN
        ,
        .lsb_err (lsb_err)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Monitor: latency on first presentation, data on handshake, silence when nothing is owed
    initial begin : monitor
        bit lat_done = 0;
        forever begin
            @(negedge clk);
            if (exp_q.size() == 0) begin
                check("no_spurious_valid", 64'(bus.out_valid), 64'd0);
            end else if (bus.out_valid) begin
                if (!lat_done) begin
                    check("latency", 64'(cyc - exp_q[0].acc), 64'd5);
                    lat_done = 1;
                end
                if (bus.out_ready) begin
                    check("sum_out", 64'(bus.sum_out), 64'(exp_q[0].sum));
`ifdef CSA_CPA_LSB_CHECK_EN
                    check("lsb_err", 64'(lsb_err), 64'(exp_q[0].lsb));
`endif
                    void'(exp_q.pop_front());
                    lat_done = 0;
                end
            end
        end
    end

    // Present one operand pair until accepted; hold keeps in_valid high afterwards
    task automatic send(input logic [24:0] s, input logic [25:0] c, input logic [26:0] r, input bit hold);
        exp_t e;
        int   n = 0;
        bus.in_valid = 1'b1;
        bus.s_in     = s;
        bus.c_in     = c;
        forever begin
            @(negedge clk);
            if (bus.in_ready) break;
            n++;
            if (n > 200) begin
                check("accept_timeout", 64'd1, 64'd0);
                bus.in_valid = 1'b0;
                return;
            end
        end
        e.sum = r;
        e.lsb = c[0];
        e.acc = cyc;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        if (!hold) bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        check("drain_done", 64'(exp_q.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    logic [24:0] tv_s [4] = '{25'h0000000, 25'h1555555, 25'h1FFFFFF, 25'h0000000};
    logic [25:0] tv_c [4] = '{26'h0000000, 26'h2AAAAAA, 26'h0000001, 26'h3FFFFFF};
    logic [26:0] tv_r [4] = '{27'h0000000, 27'h3FFFFFF, 27'h2000000, 27'h3FFFFFF};

    initial begin
        bus.in_valid  = 1'b0;
        bus.s_in      = '0;
        bus.c_in      = '0;
        bus.out_ready = 1'b1;
        #12;
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_sum_out", 64'(bus.sum_out), 64'd0);
        check("rst_busy", 64'(bus.busy), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // carry crosses chunk 0 -> 1; full ripple with MSB carry
        send(25'h00000FF, 26'h0000002, 27'h0000101, 0);
        drain();
        send(25'h1FFFFFF, 26'h3FFFFFE, 27'h5FFFFFD, 0);
        drain();
        for (int i = 0; i < 4; i++) begin
            send(tv_s[i], tv_c[i], tv_r[i], 0);
            drain();
        end

        // backpressure: result held, no new accept
        bus.out_ready = 1'b0;
        send(25'h0ABCDEF, 26'h1234560, 27'h1CF134F, 0);
        begin
            int n = 0;
            while (!bus.out_valid && n < 50) begin
                @(negedge clk);
                n++;
            end
            check("bp_valid_seen", 64'(bus.out_valid), 64'd1);
        end
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            bus.in_valid = 1'b1;
            bus.s_in     = 25'h5;
            bus.c_in     = 26'h5;
            @(negedge clk);
            check("bp_sum_stable", 64'(bus.sum_out), 64'h1CF134F);
            check("bp_in_ready", 64'(bus.in_ready), 64'd0);
            check("bp_valid_held", 64'(bus.out_valid), 64'd1);
        end
        check("bp_not_busy", 64'(bus.busy), 64'd0);
        @(posedge clk);
        #1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        drain();

        // back-to-back with in_valid held and out_ready high
        send(25'h1, 26'h2, 27'h3, 1);
        send(25'h3, 26'h4, 27'h7, 0);
        drain();

`ifdef CSA_CPA_LSB_CHECK_EN
        send(25'h0, 26'h1, 27'h1, 0);
        drain();
        send(25'h0, 26'h2, 27'h2, 0);
        drain();
`endif

        // reset during ADD chunk 1
        send(25'h0123456, 26'h0654321, 27'h0777777, 0);
        check("mid_busy", 64'(bus.busy), 64'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("mid_rst_in_ready", 64'(bus.in_ready), 64'd1);
        check("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("mid_rst_sum_out", 64'(bus.sum_out), 64'd0);
        check("mid_rst_busy", 64'(bus.busy), 64'd0);
`ifdef CSA_CPA_LSB_CHECK_EN
        check("mid_rst_lsb_err", 64'(lsb_err), 64'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        check("post_rst_busy", 64'(bus.busy), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
